// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_stage
// Brief   : MIPS IF stage; PC register, imem address, IF/ID pipeline register.
//           Optional FETCH_PERF_CNT_EN adds saturating fetch/redirect counters.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] bdst,
   input  logic [31:0] instr_in,
   output logic [31:0] imem_addr,
   output logic [31:0] if_id_pc_4,
   output logic [31:0] if_id_instr,
`ifdef FETCH_PERF_CNT_EN
   output logic        if_id_valid,
   output logic [31:0] fetch_cnt,
   output logic [31:0] redirect_cnt
`else
   output logic        if_id_valid
`endif
);

   logic [31:0] pc;
   logic [31:0] pc_4;
   logic [31:0] target;

   assign pc_4      = pc + 32'd4;
   assign target    = {bdst[31:2], 2'b00};
   assign imem_addr = pc;

   // Redirect beats stall: a taken branch must never be held off by a hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         if_id_pc_4  <= 32'h0000_0000;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (branch_taken) begin
         pc          <= target;
         if_id_pc_4  <= 32'h0000_0000;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_4;
         if_id_pc_4  <= pc_4;
         if_id_instr <= instr_in;
         if_id_valid <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt    <= 32'h0000_0000;
         redirect_cnt <= 32'h0000_0000;
      end else if (branch_taken) begin
         if (redirect_cnt != 32'hFFFF_FFFF)
            redirect_cnt <= redirect_cnt + 32'd1;
      end else if (!stall) begin
         if (fetch_cnt != 32'hFFFF_FFFF)
            fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// Bench for pc_fetch_stage: directed scenarios plus randomized traffic against
// a transaction-level fetch model.
module tb_pc_fetch_stage;

   localparam logic [31:0] RPC = 32'h0040_0000;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] bdst;
   logic [31:0] instr_in;
   logic [31:0] imem_addr;
   logic [31:0] if_id_pc_4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   pc_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .bdst(bdst), .instr_in(instr_in), .imem_addr(imem_addr),
      .if_id_pc_4(if_id_pc_4), .if_id_instr(if_id_instr),
`ifdef FETCH_PERF_CNT_EN
      .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
`else
      .if_id_valid(if_id_valid)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always_comb instr_in = mem(imem_addr);

   // Reference: the architectural fetch state updated once per edge.
   logic [31:0] m_pc = RPC, m_pc4 = 32'h0, m_instr = NOP;
   logic        m_valid = 1'b0;
   longint      m_fcnt = 0, m_rcnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = RPC; m_pc4 = 0; m_instr = NOP; m_valid = 0;
         m_fcnt = 0; m_rcnt = 0;
      end else if (branch_taken) begin
         m_pc = bdst & ~32'd3; m_pc4 = 0; m_instr = NOP; m_valid = 0;
         if (m_rcnt < 64'hFFFF_FFFF) m_rcnt++;
      end else if (!stall) begin
         m_instr = mem(m_pc);
         m_pc4 = m_pc + 32'd4;
         m_pc = m_pc4;
         m_valid = 1;
         if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("if_id_pc_4", if_id_pc_4, m_pc4);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fcnt[31:0]);
      chk("redirect_cnt", redirect_cnt, m_rcnt[31:0]);
`endif
   end

   task automatic step(input logic bt, input logic st, input logic [31:0] bd);
      branch_taken = bt; stall = st; bdst = bd;
      @(posedge clk); #1;
   endtask

   task automatic lit(input logic [31:0] a, input logic [31:0] p4,
                      input logic [31:0] ins, input logic v, input string tag);
      chk({tag, ".addr"}, imem_addr, a);
      chk({tag, ".pc_4"}, if_id_pc_4, p4);
      chk({tag, ".instr"}, if_id_instr, ins);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; bdst = 32'h0;
      @(posedge clk); #1;
      lit(RPC, 32'h0, NOP, 1'b0, "reset");
      rst = 1'b0;
      step(0, 0, 0);
      lit(32'h0040_0004, 32'h0040_0004, mem(RPC), 1'b1, "first_fetch");

      step(1, 0, 32'h0000_0100);
      lit(32'h100, 32'h0, NOP, 1'b0, "redirect");
      step(0, 0, 0);
      lit(32'h104, 32'h104, mem(32'h100), 1'b1, "after_redirect");

      step(1, 0, 32'h0000_0010);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 32'hDEAD_BEEF);
         lit(32'h10, 32'h0, NOP, 1'b0, "stall_hold");
      end
      step(0, 0, 0);
      lit(32'h14, 32'h14, mem(32'h10), 1'b1, "stall_release");
      step(0, 1, 0);
      lit(32'h14, 32'h14, mem(32'h10), 1'b1, "stall_hold_valid");

      step(1, 1, 32'h0000_0203);
      lit(32'h200, 32'h0, NOP, 1'b0, "priority_align");

      step(1, 0, 32'hFFFF_FFFC);
      step(0, 0, 0);
      lit(32'h0, 32'h0, mem(32'hFFFF_FFFC), 1'b1, "wrap");

      step(0, 1, 0);
      step(0, 1, 0);
      #2 rst = 1'b1;
      #1 lit(RPC, 32'h0, NOP, 1'b0, "async_reset");
      #2 rst = 1'b0;

`ifdef FETCH_PERF_CNT_EN
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      step(0, 1, 0);
      step(1, 0, 32'h40);
      step(1, 1, 32'h80);
      chk("fetch_cnt_lit", fetch_cnt, 32'd10);
      chk("redirect_cnt_lit", redirect_cnt, 32'd2);
`endif

      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 8) == 0, ($urandom % 4) == 0,
              (($urandom % 2) == 0) ? $urandom : {16'h0, 16'($urandom)});
         if (($urandom % 100) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end

      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
